// File: rtl/uart_pkg.sv
// Shared definitions for the stdout UART transmitter.
//   tx_state_e  : serializer FSM states
//   START_BIT / STOP_BIT / DATA_BITS : 8N1 frame constants
//   CLK_DIV_MIN : smallest usable clocks-per-bit divisor
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam int   DATA_BITS   = 8;
    localparam int   CLK_DIV_MIN = 2;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a registered occupancy count.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears pointers/count)
//   push_i      : write request; accepted when not full, or when full with a
//                 same-cycle pop
//   data_i      : byte to write
//   pop_i       : read request; ignored when empty
//   data_o      : head byte (valid while empty_o is low)
//   count_o     : current occupancy, 0..DEPTH
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok;
    logic          rd_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    assign rd_ok = pop_i && !empty_o;
    assign wr_ok = push_i && (!full_o || rd_ok) && !reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; stale entries are never observed past the count.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// Buffered 8N1 UART transmitter for a processor byte-output port.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   stdout     : byte from the processor output port
//   stdout_en  : one-cycle write strobe, one byte per high cycle
//   tx         : serial line, LSB first, idle high (registered)
//   stall      : FIFO holds FIFO_DEPTH bytes
//   busy       : frame on the line or bytes still buffered
//   overflow   : sticky, set when a write is dropped
//   level      : FIFO occupancy
module stdout_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    stdout,
    input  logic                          stdout_en,
    output logic                          tx,
    output logic                          stall,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int DIV    = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
    localparam int BAUD_W = 16;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              overflow_q;

    logic       pop;
    logic [7:0] head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       baud_done;
    logic       drop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stdout_en),
        .data_i  (stdout),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_done = (baud_q == BAUD_W'(DIV - 1));
    assign drop      = stdout_en && fifo_full && !pop;

    assign tx       = tx_q;
    assign stall    = fifo_full;
    assign busy     = (state_q != IDLE) || (level != '0);
    assign overflow = overflow_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = STOP_BIT;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    state_d = START;
                    baud_d  = '0;
                    tx_d    = START_BIT;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        // Shift so the next bit to send is always at [0];
                        // drive it now since tx is registered.
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle cycle between STOP and START.
                        pop     = 1'b1;
                        shreg_d = head;
                        state_d = START;
                        tx_d    = START_BIT;
                    end else begin
                        state_d = IDLE;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = STOP_BIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            tx_q       <= STOP_BIT;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed testbench for stdout_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_stdout_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int NMAX       = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    stdout = 8'h00;
    logic          stdout_en = 1'b0;
    logic          tx;
    logic          stall;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] level;

    int checks = 0;
    int failures = 0;

    logic [7:0]    wr_byte [NMAX];
    bit            wr_en   [NMAX];
    bit            cap     [NMAX];
    logic [LW-1:0] lvl_tr  [NMAX];
    bit            stall_tr[NMAX];
    bit            ovf_tr  [NMAX];
    bit            busy_tr [NMAX];

    always #5 clk = ~clk;

    stdout_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stdout    (stdout),
        .stdout_en (stdout_en),
        .tx        (tx),
        .stall     (stall),
        .busy      (busy),
        .overflow  (overflow),
        .level     (level)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        stdout_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clr_sched;
        for (int i = 0; i < NMAX; i++) begin
            wr_en[i]   = 1'b0;
            wr_byte[i] = 8'h00;
        end
    endtask

    // Index c holds what was driven into edge c and what was seen just after it.
    task automatic run_sched(input int n);
        for (int c = 0; c < n; c++) begin
            stdout_en = wr_en[c];
            stdout    = wr_byte[c];
            tick();
            cap[c]      = tx;
            lvl_tr[c]   = level;
            stall_tr[c] = stall;
            ovf_tr[c]   = overflow;
            busy_tr[c]  = busy;
        end
        stdout_en = 1'b0;
    endtask

    function automatic logic [39:0] exp_frame(input logic [7:0] b);
        logic [39:0] f;
        for (int j = 0; j < 40; j++) begin
            if (j < CLK_DIV)            f[j] = 1'b0;
            else if (j < 9 * CLK_DIV)   f[j] = b[(j - CLK_DIV) / CLK_DIV];
            else                        f[j] = 1'b1;
        end
        return f;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [7:0] b);
        logic [39:0] got;
        for (int j = 0; j < 40; j++) got[j] = cap[start + j];
        check_val(tag, {24'h0, got}, {24'h0, exp_frame(b)});
    endtask

    initial begin : main
        logic [7:0] bits48 [8];
        int peak;

        // ---------------- reset state
        do_reset();
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_level", level, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_stall", stall, 0);

        // ---------------- single byte 0x48 from idle
        clr_sched();
        wr_en[0] = 1'b1; wr_byte[0] = 8'h48;
        run_sched(42);
        check_val("t1_tx_write_edge", cap[0], 1);
        check_val("t1_lvl_write_edge", lvl_tr[0], 1);
        check_val("t1_tx_start", cap[1], 0);
        check_val("t1_lvl_after_pop", lvl_tr[1], 0);
        bits48 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0};
        for (int k = 0; k < 8; k++)
            check_val($sformatf("t1_bit%0d", k), cap[1 + 4 + 4 * k + 2], bits48[k][0]);
        check_val("t1_stop", cap[38], 1);
        check_frame("t1_frame", 1, 8'h48);
        check_val("t1_busy_last", busy_tr[40], 1);
        check_val("t1_busy_drop", busy_tr[41], 0);

        // ---------------- three bytes four cycles apart
        clr_sched();
        wr_en[0] = 1'b1; wr_byte[0] = 8'h41;
        wr_en[4] = 1'b1; wr_byte[4] = 8'h42;
        wr_en[8] = 1'b1; wr_byte[8] = 8'h43;
        run_sched(122);
        check_frame("t2_frame0", 1, 8'h41);
        check_frame("t2_frame1", 41, 8'h42);
        check_frame("t2_frame2", 81, 8'h43);
        peak = 0;
        for (int c = 0; c < 122; c++) if (int'(lvl_tr[c]) > peak) peak = int'(lvl_tr[c]);
        check_val("t2_level_peak", peak, 2);
        check_val("t2_busy_end", busy_tr[120], 1);
        check_val("t2_busy_drop", busy_tr[121], 0);

        // ---------------- overflow with six back-to-back writes
        do_reset();
        clr_sched();
        for (int i = 0; i < 6; i++) begin
            wr_en[i] = 1'b1;
            wr_byte[i] = 8'hA1 + 8'(i);
        end
        run_sched(202);
        check_val("t3_stall_pre", stall_tr[3], 0);
        check_val("t3_stall", stall_tr[4], 1);
        check_val("t3_ovf_pre", ovf_tr[4], 0);
        check_val("t3_ovf", ovf_tr[5], 1);
        check_val("t3_level_full", lvl_tr[5], 4);
        for (int i = 0; i < 5; i++)
            check_frame($sformatf("t3_frame%0d", i), 1 + 40 * i, 8'hA1 + 8'(i));
        check_val("t3_idle_after", cap[201], 1);
        check_val("t3_busy_end", busy_tr[201], 0);
        check_val("t3_ovf_sticky", ovf_tr[201], 1);

        // ---------------- write while full in the STOP pop cycle
        do_reset();
        clr_sched();
        for (int i = 0; i < 5; i++) begin
            wr_en[i] = 1'b1;
            wr_byte[i] = 8'hB1 + 8'(i);
        end
        wr_en[41] = 1'b1; wr_byte[41] = 8'h55;
        run_sched(243);
        check_val("t4_level_pre", lvl_tr[40], 4);
        check_val("t4_stall_pre", stall_tr[40], 1);
        check_val("t4_level_pop", lvl_tr[41], 4);
        check_val("t4_ovf_pop", ovf_tr[41], 0);
        for (int i = 0; i < 5; i++)
            check_frame($sformatf("t4_frame%0d", i), 1 + 40 * i, 8'hB1 + 8'(i));
        check_frame("t4_frame55", 201, 8'h55);
        check_val("t4_busy_end", busy_tr[241], 0);
        check_val("t4_ovf_end", ovf_tr[242], 0);

        // ---------------- reset during data bit 3
        do_reset();
        clr_sched();
        wr_en[0] = 1'b1; wr_byte[0] = 8'h00;
        wr_en[1] = 1'b1; wr_byte[1] = 8'h00;
        run_sched(18);
        check_val("t5_tx_bit3", cap[17], 0);
        check_val("t5_busy_bit3", busy_tr[17], 1);
        check_val("t5_level_bit3", lvl_tr[17], 1);
        reset = 1'b1;
        stdout_en = 1'b1;
        stdout = 8'hAA;
        tick();
        check_val("t5_rst_tx", tx, 1);
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_level", level, 0);
        check_val("t5_rst_ovf", overflow, 0);
        reset = 1'b0;
        stdout_en = 1'b0;
        tick();
        check_val("t5_ignored_level", level, 0);
        check_val("t5_ignored_busy", busy, 0);
        tick();
        check_val("t5_idle_tx", tx, 1);
        clr_sched();
        wr_en[0] = 1'b1; wr_byte[0] = 8'h0F;
        run_sched(42);
        check_frame("t5_frame0F", 1, 8'h0F);
        check_val("t5_busy_drop", busy_tr[41], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stdout_uart_tx.md
STDOUT_UART_TX -- requirements
Module: stdout_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: byte buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 stdout  input  8  byte from the processor output port.
REQ-006 stdout_en  input  1  byte valid; one-cycle pulse per byte; every high cycle is one write.
REQ-007 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 stall  output  1  high when the FIFO holds FIFO_DEPTH bytes; drives processor en low externally.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 overflow  output  1  sticky; set when a write is dropped.
REQ-011 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 A write with FIFO not full, or full with a same-cycle pop, SHALL be stored; otherwise the byte SHALL be dropped and overflow set.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE with FIFO non-empty SHALL pop the head byte and enter START at the same edge; tx low from that edge.
REQ-015 An empty-FIFO write sampled at edge N SHALL drive tx low from edge N+1 (one-cycle latency).
REQ-016 START, each of 8 DATA bits, and STOP SHALL each last exactly CLK_DIV cycles; a frame is 10*CLK_DIV cycles.
REQ-017 DATA SHALL shift LSB first using a 3-bit bit index; index 7 completion SHALL enter STOP.
REQ-018 STOP completion with FIFO non-empty SHALL pop and enter START at the same edge (no idle gap); otherwise it SHALL enter IDLE.
REQ-019 tx SHALL be registered and glitch-free; high in IDLE and STOP.
REQ-020 A simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 stall SHALL equal (level == FIFO_DEPTH); busy SHALL equal (state != IDLE) or (level != 0).
REQ-022 The baud counter SHALL count 0..CLK_DIV-1 and reload 0 at each bit boundary.

Reset
REQ-023 Reset SHALL set tx=1, state=IDLE, level=0, pointers=0, baud counter=0, bit index=0, overflow=0.
REQ-024 Reset mid-frame SHALL abort the frame and discard the FIFO contents; tx SHALL be high from the next edge.
REQ-025 A stdout_en sampled in the same cycle as reset SHALL be ignored.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum, frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8), and the CLK_DIV lower-bound constant.
REQ-027 Buffering SHALL be one sub-module, byte_fifo (synchronous, registered count, full/empty flags); the serializer FSM stays in stdout_uart_tx.

Verification
REQ-028 CLK_DIV=4: write 0x48 when idle -> tx low at next edge; tx bits 0,0,0,1,0,0,1,0, then 1, each 4 cycles; busy drops after 40 cycles.
REQ-029 CLK_DIV=4: write 0x41, 0x42, 0x43 four cycles apart -> three contiguous 40-cycle frames, no idle cycle between frames; level peaks at 2.
REQ-030 FIFO_DEPTH=4, idle: write 6 bytes on consecutive cycles -> bytes 1..5 sent in order; byte 6 dropped; overflow=1 and stall=1 in the cycle after byte 5.
REQ-031 FIFO full during STOP completion; write 0x55 in the pop cycle -> byte accepted, level stays 4, overflow stays 0.
REQ-032 Reset asserted during data bit 3 -> next edge tx=1, busy=0, level=0; a following write 0x0F starts a clean frame.
